// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//   Streams a contiguous address range out of one SRAM bank onto a
//   valid/ready output. A 2-entry registered FIFO absorbs the 1-cycle SRAM
//   read latency so the stream runs at one word per cycle when the consumer
//   is ready.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : command strobe, sampled only while idle
//   base_addr, length : transfer descriptor, latched with start
//   busy, done        : transfer in progress / one-cycle completion pulse
//   sram_en, sram_we  : read issue (we is always 0)
//   sram_addr         : read address (wraps modulo 2^ADDR_WIDTH)
//   sram_rdata        : SRAM read data, valid the cycle after sram_en
//   m_valid, m_data   : output word (FIFO head)
//   m_last            : marks the final word of the transfer
//   m_ready           : consumer accept
//
// States
//   IDLE  | waiting for start
//   READ  | issuing reads under the FIFO credit rule
//   DRAIN | all reads issued, waiting for the last word to be accepted
module sram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issue_q, issue_d;
  logic [LEN_WIDTH-1:0]  out_q, out_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] fifo0_q, fifo0_d;
  logic [DATA_WIDTH-1:0] fifo1_q, fifo1_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  pop;
  logic [2:0]            occ_after;
  logic                  issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issue_q    <= '0;
      out_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      out_q      <= out_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    m_valid   = (count_q != 2'd0);
    m_data    = rd_ptr_q ? fifo1_q : fifo0_q;
    pop       = m_valid && m_ready;
    // Occupancy the FIFO will have once the outstanding read lands and this
    // cycle's pop retires; a new read may only go out if that leaves a slot.
    occ_after = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue     = (state_q == S_READ) && (occ_after < 3'd2);
    sram_en   = issue;
    sram_we   = 1'b0;
    sram_addr = base_q + issue_q[ADDR_WIDTH-1:0];
    m_last    = m_valid && (out_q == (len_q - LEN_WIDTH'(1)));
    busy      = (state_q != S_IDLE);
    done      = done_q;
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issue_d    = issue_q;
    out_d      = out_q;
    done_d     = 1'b0;
    inflight_d = issue;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = 2'(3'(count_q) + 3'(inflight_q) - 3'(pop));

    // Returning read data is captured unconditionally; credit guarantees room.
    if (inflight_q) begin
      if (wr_ptr_q) fifo1_d = sram_rdata;
      else          fifo0_d = sram_rdata;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      out_d    = out_q + LEN_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          issue_d = '0;
          out_d   = '0;
          state_d = (length == '0) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          issue_d = issue_q + LEN_WIDTH'(1);
          if ((issue_q + LEN_WIDTH'(1)) == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finishes in the cycle of the final handshake (or at once for len=0).
        if ((out_q + LEN_WIDTH'(pop)) == len_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
